// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, mul/div, memory
// wait-state and branch-redirect conditions into per-stage enables and bubbles.
module pipeline_sequencer #(
   parameter int MULDIV_LAT = 4,
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d_available,
   input  logic             d_jmp_taken,
   input  logic             e_muldiv,
   input  logic             m_mem_req,
   input  logic             dmem_ready,
   input  logic             imem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             ex_mem_en,
   output logic             ex_mem_bubble,
   output logic             mem_wb_en,
   output logic             mem_wb_bubble,
   output logic             muldiv_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, MULDIV, MEM_WAIT} state_t;

   localparam int CW          = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
   localparam int MD_LOAD_INT = (MULDIV_LAT > 2) ? (MULDIV_LAT - 2) : 0;
   localparam logic [CW-1:0]    MD_LOAD   = CW'(MD_LOAD_INT);
   localparam logic [CW-1:0]    MD_ONE    = CW'(1);
   localparam logic [CW-1:0]    MD_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam bit               HAS_STALL = (MULDIV_LAT > 1);
   localparam bit               NO_SLOT   = (DELAY_SLOT == 0);

   state_t           state_q, state_d;
   state_t           retState_q, retState_d;
   state_t           effState;
   logic [CW-1:0]    mdCnt_q, mdCnt_d;
   logic             mdDone_q, mdDone_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

   logic memStall, mdTrigger, mdHold;
   logic pcEn, ifIdEn, ifIdFlush, idExEn, idExBubble;
   logic exMemEn, exMemBubble, memWbEn, memWbBubble;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         retState_q <= RUN;
         mdCnt_q    <= '0;
         mdDone_q   <= 1'b0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         retState_q <= retState_d;
         mdCnt_q    <= mdCnt_d;
         mdDone_q   <= mdDone_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   // The cycle that releases MEM_WAIT behaves exactly like the state it returns to.
   always_comb begin
      effState  = (state_q == MEM_WAIT) ? retState_q : state_q;
      memStall  = m_mem_req & ~dmem_ready;
      mdTrigger = (effState == RUN) & e_muldiv & ~mdDone_q & HAS_STALL;
      mdHold    = (effState == MULDIV) | mdTrigger;

      pcEn        = 1'b1;
      ifIdEn      = 1'b1;
      ifIdFlush   = 1'b0;
      idExEn      = 1'b1;
      idExBubble  = 1'b0;
      exMemEn     = 1'b1;
      exMemBubble = 1'b0;
      memWbEn     = 1'b1;
      memWbBubble = 1'b0;

      if (memStall) begin
         pcEn        = 1'b0;
         ifIdEn      = 1'b0;
         idExEn      = 1'b0;
         exMemEn     = 1'b0;
         memWbBubble = 1'b1;
      end else if (mdHold) begin
         pcEn        = 1'b0;
         ifIdEn      = 1'b0;
         idExEn      = 1'b0;
         exMemBubble = 1'b1;
      end else if (!d_available) begin
         pcEn       = 1'b0;
         ifIdEn     = 1'b0;
         idExBubble = 1'b1;
      end else if (!imem_ready) begin
         pcEn      = 1'b0;
         ifIdFlush = 1'b1;
      end else if (d_jmp_taken && NO_SLOT) begin
         ifIdFlush = 1'b1;
      end
   end

   // Memory stalls freeze md_cnt; md_done blocks the finished op from re-arming.
   always_comb begin
      state_d    = state_q;
      retState_d = retState_q;
      mdCnt_d    = mdCnt_q;
      mdDone_d   = mdDone_q;
      stallCnt_d = stallCnt_q;

      if (!pcEn && (stallCnt_q != CNT_MAX)) begin
         stallCnt_d = stallCnt_q + 1'b1;
      end

      if (memStall) begin
         if (state_q != MEM_WAIT) begin
            state_d    = MEM_WAIT;
            retState_d = effState;
         end
      end else begin
         state_d = effState;
         if (effState == MULDIV) begin
            mdCnt_d = mdCnt_q - 1'b1;
            if (mdCnt_q <= MD_ONE) begin
               state_d  = RUN;
               mdCnt_d  = MD_ZERO;
               mdDone_d = 1'b1;
            end
         end else if (mdTrigger) begin
            mdCnt_d = MD_LOAD;
            if (MD_LOAD_INT == 0) begin
               mdDone_d = 1'b1;
            end else begin
               state_d = MULDIV;
            end
         end else begin
            mdDone_d = 1'b0;
         end
      end
   end

   assign pc_en         = rst_n & pcEn;
   assign if_id_en      = rst_n & ifIdEn;
   assign if_id_flush   = rst_n & ifIdFlush;
   assign id_ex_en      = rst_n & idExEn;
   assign id_ex_bubble  = rst_n & idExBubble;
   assign ex_mem_en     = rst_n & exMemEn;
   assign ex_mem_bubble = rst_n & exMemBubble;
   assign mem_wb_en     = rst_n & memWbEn;
   assign mem_wb_bubble = rst_n & memWbBubble;
   assign muldiv_busy   = rst_n & (state_q == MULDIV);
   assign stall_cnt     = stallCnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: two instances (no delay slot / 32-bit counter and
// delay slot / 4-bit counter) share stimulus and are compared against a cycle model.
module tb_pipeline_sequencer;

   localparam int LAT = 4;

   typedef struct {
      logic [5:0] stim;
      logic [8:0] expA;
      logic       expFlushB;
   } vec_t;

   logic clk, rstN;
   logic dAvail, jmpTaken, eMuldiv, memReq, dReady, iReady;

   logic pcEnA, ifIdEnA, ifIdFlushA, idExEnA, idExBubA, exMemEnA, exMemBubA, memWbEnA, memWbBubA, busyA;
   logic pcEnB, ifIdEnB, ifIdFlushB, idExEnB, idExBubB, exMemEnB, exMemBubB, memWbEnB, memWbBubB, busyB;
   logic [31:0] stallA;
   logic [3:0]  stallB;
   logic [8:0]  packA, packB;

   int checks = 0;
   int passed = 0;

   bit     mInProg, mMdDone, mPrevStall;
   int     mRemain;
   longint mStallA;
   int     mStallB;

   vec_t vecs[10];

   pipeline_sequencer #(.MULDIV_LAT(LAT), .DELAY_SLOT(0), .CNT_W(32)) dutA (
      .clk(clk), .rst_n(rstN), .d_available(dAvail), .d_jmp_taken(jmpTaken),
      .e_muldiv(eMuldiv), .m_mem_req(memReq), .dmem_ready(dReady), .imem_ready(iReady),
      .pc_en(pcEnA), .if_id_en(ifIdEnA), .if_id_flush(ifIdFlushA), .id_ex_en(idExEnA),
      .id_ex_bubble(idExBubA), .ex_mem_en(exMemEnA), .ex_mem_bubble(exMemBubA),
      .mem_wb_en(memWbEnA), .mem_wb_bubble(memWbBubA), .muldiv_busy(busyA), .stall_cnt(stallA));

   pipeline_sequencer #(.MULDIV_LAT(LAT), .DELAY_SLOT(1), .CNT_W(4)) dutB (
      .clk(clk), .rst_n(rstN), .d_available(dAvail), .d_jmp_taken(jmpTaken),
      .e_muldiv(eMuldiv), .m_mem_req(memReq), .dmem_ready(dReady), .imem_ready(iReady),
      .pc_en(pcEnB), .if_id_en(ifIdEnB), .if_id_flush(ifIdFlushB), .id_ex_en(idExEnB),
      .id_ex_bubble(idExBubB), .ex_mem_en(exMemEnB), .ex_mem_bubble(exMemBubB),
      .mem_wb_en(memWbEnB), .mem_wb_bubble(memWbBubB), .muldiv_busy(busyB), .stall_cnt(stallB));

   assign packA = {pcEnA, ifIdEnA, ifIdFlushA, idExEnA, idExBubA, exMemEnA, exMemBubA, memWbEnA, memWbBubA};
   assign packB = {pcEnB, ifIdEnB, ifIdFlushB, idExEnB, idExBubB, exMemEnB, exMemBubB, memWbEnB, memWbBubB};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   task automatic modelReset();
      mInProg = 0; mMdDone = 0; mPrevStall = 0; mRemain = 0; mStallA = 0; mStallB = 0;
   endtask

   task automatic applyStimulus(input logic [5:0] v);
      @(negedge clk);
      {dAvail, jmpTaken, eMuldiv, memReq, dReady, iReady} = v;
   endtask

   // Model: a mul/div needs LAT-1 held cycles that are not lost to a memory stall.
   task automatic checkOutput();
      logic [8:0] e;
      logic       fB, stall1, active, busy;
      #2;
      stall1 = memReq & ~dReady;
      active = mInProg | (eMuldiv & ~mMdDone);
      busy   = mInProg & ~mPrevStall;
      fB     = 1'b0;
      if (stall1)        e = 9'b000000011;
      else if (active)   e = 9'b000001110;
      else if (!dAvail)  e = 9'b000111010;
      else if (!iReady) begin e = 9'b011101010; fB = 1'b1; end
      else if (jmpTaken) e = 9'b111101010;
      else               e = 9'b110101010;
      checkEq("ctrlA", 64'(packA), 64'(e));
      checkEq("ctrlB", 64'(packB), 64'({e[8:7], fB, e[5:0]}));
      checkEq("busy", 64'({busyA, busyB}), 64'({busy, busy}));
      checkEq("stallA", 64'(stallA), 64'(mStallA));
      checkEq("stallB", 64'(stallB), 64'(mStallB));
      if (!stall1 && active) begin
         if (!mInProg) begin mInProg = 1; mRemain = LAT - 1; end
         mRemain--;
         if (mRemain == 0) begin mInProg = 0; mMdDone = 1; end
      end else if (!stall1) begin
         mMdDone = 0;
      end
      mPrevStall = stall1;
      if (!e[8]) begin
         mStallA++;
         if (mStallB < 15) mStallB++;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0;
      {dAvail, jmpTaken, eMuldiv, memReq, dReady, iReady} = 6'b100011;
      @(negedge clk);
      checkEq("resetCtrl", 64'({packA, packB, busyA, busyB}), 64'd0);
      checkEq("resetCnt", 64'({stallA, stallB}), 64'd0);
      rstN = 1'b1;
      modelReset();
   endtask

   initial begin
      logic [4:0] t3Exb, t3Busy;
      logic [6:0] t4Wb, t4Exb, t4Busy;
      vecs[0] = '{6'b100011, 9'b110101010, 1'b0};
      vecs[1] = '{6'b000011, 9'b000111010, 1'b0};
      vecs[2] = '{6'b100010, 9'b011101010, 1'b1};
      vecs[3] = '{6'b110011, 9'b111101010, 1'b0};
      vecs[4] = '{6'b100101, 9'b000000011, 1'b0};
      vecs[5] = '{6'b100111, 9'b110101010, 1'b0};
      vecs[6] = '{6'b000010, 9'b000111010, 1'b0};
      vecs[7] = '{6'b010011, 9'b000111010, 1'b0};
      vecs[8] = '{6'b010100, 9'b000000011, 1'b0};
      vecs[9] = '{6'b110010, 9'b011101010, 1'b1};

      rstN = 1'b0;
      {dAvail, jmpTaken, eMuldiv, memReq, dReady, iReady} = 6'b100011;
      modelReset();
      doReset();

      // T1: ten idle cycles
      for (int i = 0; i < 10; i++) begin
         applyStimulus(6'b100011);
         checkOutput();
      end
      checkEq("t1Stall", 64'(stallA), 64'd0);

      // Single-cycle combinational vectors
      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].stim);
         checkOutput();
         checkEq("vecA", 64'(packA), 64'(vecs[i].expA));
         checkEq("vecFlushB", 64'(ifIdFlushB), 64'(vecs[i].expFlushB));
      end

      // T3: held mul/div, three bubbles, two busy cycles, then released
      doReset();
      t3Exb = 5'b11100; t3Busy = 5'b01100;
      for (int i = 0; i < 5; i++) begin
         applyStimulus((i < 4) ? 6'b101011 : 6'b100011);
         checkOutput();
         checkEq("t3Exb", 64'(exMemBubA), 64'(t3Exb[4-i]));
         checkEq("t3Busy", 64'(busyA), 64'(t3Busy[4-i]));
         if (i == 3) checkEq("t3Stall", 64'(stallA), 64'd3);
      end

      // T4: data-memory stall of three cycles overlapping the last MULDIV cycle
      doReset();
      t4Wb = 7'b0011100; t4Exb = 7'b1100010; t4Busy = 7'b0110000;
      for (int i = 0; i < 7; i++) begin
         if (i < 2)       applyStimulus(6'b101011);
         else if (i < 5)  applyStimulus(6'b101101);
         else if (i == 5) applyStimulus(6'b101111);
         else             applyStimulus(6'b100011);
         checkOutput();
         checkEq("t4Wb", 64'(memWbBubA), 64'(t4Wb[6-i]));
         checkEq("t4Exb", 64'(exMemBubA), 64'(t4Exb[6-i]));
         checkEq("t4Busy", 64'(busyA), 64'(t4Busy[6-i]));
      end

      // T6: asynchronous reset in the middle of MULDIV
      doReset();
      applyStimulus(6'b101011); checkOutput();
      applyStimulus(6'b101011); checkOutput();
      checkEq("t6BusyBefore", 64'(busyA), 64'd1);
      @(posedge clk);
      #1 rstN = 1'b0;
      #1;
      checkEq("t6Ctrl", 64'({packA, busyA, busyB}), 64'd0);
      checkEq("t6Cnt", 64'({stallA, stallB}), 64'd0);
      modelReset();
      @(negedge clk);
      {dAvail, jmpTaken, eMuldiv, memReq, dReady, iReady} = 6'b100011;
      rstN = 1'b1;

      // Counter saturation on the 4-bit instance
      for (int i = 0; i < 20; i++) begin
         applyStimulus(6'b000011);
         checkOutput();
      end
      applyStimulus(6'b100011);
      checkOutput();
      checkEq("satB", 64'(stallB), 64'd15);
      checkEq("satA", 64'(stallA), 64'd20);

      // Randomised traffic against the model
      doReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus({($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
                        ($urandom % 3) == 0, ($urandom % 3) != 0, ($urandom % 5) != 0});
         checkOutput();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
